// File: rtl/uio_tx_port.sv
// uio_tx_port: nibble-wide parallel-port transmitter on the bidirectional uio pins.
//
// Bytes from core logic are queued in a small FIFO. Each byte goes out as two
// 4-bit nibbles, low nibble first, with a four-phase strobe/acknowledge
// handshake:
//   1. data is presented on uio_out[3:0];
//   2. after SETUP_CYC stable cycles, STB (uio_out[4]) rises;
//   3. the reader raises ACK (uio_in[5]), and STB falls;
//   4. the reader drops ACK, and the next nibble or byte can follow.
// ACK is synchronised by two flops before the FSM sees it.
//
// Optional feature macro: UIO_TX_TIMEOUT_EN. When it is defined, a wait
// for an ACK edge that lasts TIMEOUT_CYC cycles abandons the current byte and
// sets the sticky timeout_err flag. When it is undefined, the FSM waits forever
// and timeout_err is tied to 0.
//
// Ports:
//   i_clk          clock; all logic runs on the rising edge
//   i_rst          synchronous, active-high reset
//   i_tx_data      byte to transmit
//   i_tx_valid     i_tx_data valid
//   o_tx_ready     FIFO can accept a byte (registered !full)
//   i_uio_in       pad inputs; only bit 5 (ACK) is used
//   o_uio_out      [3:0] data nibble, [4] STB, [7:5] driven 0
//   o_uio_oe       output enables: 0x00 in reset, 0x1F otherwise
//   o_busy         FIFO non-empty or a transfer in progress
//   o_timeout_err  sticky acknowledge-timeout flag

module uio_tx_port #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   input  logic [7:0] i_uio_in,
   output logic [7:0] o_uio_out,
   output logic [7:0] o_uio_oe,
   output logic       o_busy,
   output logic       o_timeout_err
);

   localparam int unsigned   AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW         = AW + 1;
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [3:0]    SETUP_LAST = 4'(SETUP_CYC - 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSetup  = 2'd1,
      StWaitHi = 2'd2,
      StWaitLo = 2'd3
   } state_e;

   // FIFO
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_tx_ready;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;

   // Pad side
   logic [7:0]    r_uio_oe;
   logic          r_ack_meta;
   logic          r_ack_s;

   // FSM
   state_e        r_state;
   state_e        w_state_nxt;
   logic [3:0]    r_data;
   logic [3:0]    w_data_nxt;
   logic [3:0]    r_hi;
   logic [3:0]    w_hi_nxt;
   logic          r_nib;
   logic          w_nib_nxt;
   logic          r_stb;
   logic          w_stb_nxt;
   logic [3:0]    r_setup_cnt;
   logic [3:0]    w_setup_cnt_nxt;
   logic          w_timeout;

   logic          w_unused;

   assign w_unused = ^{i_uio_in[7:6], i_uio_in[4:0]};

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   assign w_empty = (r_count == '0);
   assign w_push  = i_tx_valid && r_tx_ready;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_tx_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_tx_ready <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count    <= w_count_nxt;
         r_tx_ready <= (w_count_nxt != FULL_CNT);
      end
   end

   // ------------------------------------------------------------------
   // Handshake FSM
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_data_nxt      = r_data;
      w_hi_nxt        = r_hi;
      w_nib_nxt       = r_nib;
      w_stb_nxt       = r_stb;
      w_setup_cnt_nxt = r_setup_cnt;
      w_pop           = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (!w_empty) begin
               w_pop           = 1'b1;
               w_data_nxt      = r_mem[r_rptr][3:0];
               w_hi_nxt        = r_mem[r_rptr][7:4];
               w_nib_nxt       = 1'b0;
               w_setup_cnt_nxt = '0;
               w_state_nxt     = StSetup;
            end
         end
         StSetup: begin
            if (r_setup_cnt == SETUP_LAST) begin
               w_stb_nxt       = 1'b1;
               w_setup_cnt_nxt = '0;
               w_state_nxt     = StWaitHi;
            end else begin
               w_setup_cnt_nxt = r_setup_cnt + 4'd1;
            end
         end
         StWaitHi: begin
            // Timeout drops the whole byte, even if only the high nibble is left.
            if (w_timeout) begin
               w_stb_nxt   = 1'b0;
               w_state_nxt = StIdle;
            end else if (r_ack_s) begin
               w_stb_nxt   = 1'b0;
               w_state_nxt = StWaitLo;
            end
         end
         StWaitLo: begin
            if (w_timeout) begin
               w_state_nxt = StIdle;
            end else if (!r_ack_s) begin
               if (!r_nib) begin
                  w_nib_nxt       = 1'b1;
                  w_data_nxt      = r_hi;
                  w_setup_cnt_nxt = '0;
                  w_state_nxt     = StSetup;
               end else begin
                  w_state_nxt = StIdle;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_data      <= '0;
         r_hi        <= '0;
         r_nib       <= 1'b0;
         r_stb       <= 1'b0;
         r_setup_cnt <= '0;
         r_uio_oe    <= 8'h00;
         r_ack_meta  <= 1'b0;
         r_ack_s     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_data      <= w_data_nxt;
         r_hi        <= w_hi_nxt;
         r_nib       <= w_nib_nxt;
         r_stb       <= w_stb_nxt;
         r_setup_cnt <= w_setup_cnt_nxt;
         r_uio_oe    <= 8'h1F;
         r_ack_meta  <= i_uio_in[5];
         r_ack_s     <= r_ack_meta;
      end
   end

   // ------------------------------------------------------------------
   // Optional acknowledge timeout
   // ------------------------------------------------------------------
`ifdef UIO_TX_TIMEOUT_EN
   localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] r_to_cnt;
   logic          r_timeout_err;

   // Fires on the TIMEOUT_CYC-th cycle spent in one wait state.
   assign w_timeout = ((r_state == StWaitHi) || (r_state == StWaitLo)) &&
                      (r_to_cnt == TO_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_state_nxt != r_state) begin
            r_to_cnt <= '0;
         end else if ((r_state == StWaitHi) || (r_state == StWaitLo)) begin
            r_to_cnt <= r_to_cnt + TW'(1);
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign o_timeout_err = r_timeout_err;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = |TIMEOUT_CYC;
   assign w_timeout        = 1'b0;
   assign o_timeout_err    = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign o_tx_ready = r_tx_ready;
   assign o_uio_out  = {3'b000, r_stb, r_data};
   assign o_uio_oe   = r_uio_oe;
   assign o_busy     = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_uio_tx_port.sv
// Directed testbench for uio_tx_port: a model reader answers the strobe
// handshake and a monitor collects the nibbles presented at each STB rise.

module tb_uio_tx_port;

   localparam int unsigned DEPTH     = 4;
   localparam int unsigned SETUP_CYC = 2;
   localparam int unsigned TIMEOUT   = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       busy;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   // Reader model controls
   bit rd_en    = 1'b0;
   int rd_delay = 0;

   // Monitor results
   logic [3:0] nibq[$];
   int         min_stable = 1000;
   bit         data_moved = 1'b0;
   int         min_hi     = 1000;

   always #5 clk = ~clk;

   uio_tx_port #(
      .DEPTH       (DEPTH),
      .SETUP_CYC   (SETUP_CYC),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_tx_data     (tx_data),
      .i_tx_valid    (tx_valid),
      .o_tx_ready    (tx_ready),
      .i_uio_in      (uio_in),
      .o_uio_out     (uio_out),
      .o_uio_oe      (uio_oe),
      .o_busy        (busy),
      .o_timeout_err (timeout_err)
   );

   // Reader: raises ACK rd_delay cycles after seeing STB high, drops it
   // rd_delay cycles after seeing STB low. Unused uio_in bits are held high.
   initial begin
      logic ack;
      int   cnt;
      ack    = 1'b0;
      cnt    = 0;
      uio_in = 8'hDF;
      forever begin
         @(negedge clk);
         if (rst || !rd_en) begin
            ack = 1'b0;
            cnt = 0;
         end else if (uio_out[4] && !ack) begin
            if (cnt >= rd_delay) begin
               ack = 1'b1;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else if (!uio_out[4] && ack) begin
            if (cnt >= rd_delay) begin
               ack = 1'b0;
               cnt = 0;
            end else begin
               cnt++;
            end
         end
         uio_in = ack ? 8'hFF : 8'hDF;
      end
   end

   // Monitor: nibble capture at STB rise, setup stability, STB high length.
   initial begin
      logic       prev_stb;
      logic [3:0] prev_data;
      int         stable;
      int         hi_len;
      prev_stb  = 1'b0;
      prev_data = 4'h0;
      stable    = 0;
      hi_len    = 0;
      forever begin
         @(negedge clk);
         if (uio_out[3:0] != prev_data) begin
            stable = 0;
            if (uio_out[4] && prev_stb) data_moved = 1'b1;
         end else begin
            stable++;
         end
         if (uio_out[4] && !prev_stb) begin
            nibq.push_back(uio_out[3:0]);
            if (stable < min_stable) min_stable = stable;
         end
         if (uio_out[4]) begin
            hi_len++;
         end else if (prev_stb) begin
            if (hi_len < min_hi) min_hi = hi_len;
            hi_len = 0;
         end
         prev_stb  = uio_out[4];
         prev_data = uio_out[3:0];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Helpers (stimulus and bounded waits only)
   // ------------------------------------------------------------------
   task automatic push(input logic [7:0] b, output int waited);
      waited   = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && waited < 500) begin
         @(posedge clk);
         #1;
         waited++;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_nibs(input int n, input int bound, output bit ok);
      int k;
      k = 0;
      while (nibq.size() < n && k < bound) begin
         @(posedge clk);
         #1;
         k++;
      end
      ok = (nibq.size() >= n);
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      int k;
      k = 0;
      while (busy && k < bound) begin
         @(posedge clk);
         #1;
         k++;
      end
      ok = !busy;
   endtask

   task automatic wait_stb(input logic lvl, input int bound, output int n);
      n = 0;
      while (uio_out[4] !== lvl && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset;
      bit   changed;
      logic [18:0] snap;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (uio_oe !== 8'h00) begin
         errors++;
         $display("FAIL reset_oe: got %h expected 00", uio_oe);
      end
      checks++;
      if (uio_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_out: got %h expected 00", uio_out);
      end
      checks++;
      if (tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 0", tx_ready);
      end
      checks++;
      if (busy !== 1'b0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy_err: got %b%b expected 00", busy, timeout_err);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({uio_oe, uio_out, tx_ready, busy, timeout_err} !== {8'h1F, 8'h00, 3'b100}) begin
         errors++;
         $display("FAIL post_reset: got oe=%h out=%h rdy=%b busy=%b err=%b expected 1f 00 1 0 0",
                  uio_oe, uio_out, tx_ready, busy, timeout_err);
      end
      changed = 1'b0;
      snap    = '0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (!changed && {uio_oe, uio_out, tx_ready, busy, timeout_err} !== {8'h1F, 8'h00, 3'b100})
         begin
            changed = 1'b1;
            snap    = {uio_oe, uio_out, tx_ready, busy, timeout_err};
         end
      end
      checks++;
      if (changed) begin
         errors++;
         $display("FAIL idle_hold: got %h expected %h", snap, {8'h1F, 8'h00, 3'b100});
      end
   endtask

   task automatic test_single;
      int   w;
      int   n;
      bit   ok;
      logic [7:0] got;
      rd_en      = 1'b1;
      rd_delay   = 0;
      nibq.delete();
      min_stable = 1000;
      data_moved = 1'b0;
      push(8'hA5, w);
      wait_stb(1'b1, 20, n);
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL single_stb_latency: got %0d expected 3", n);
      end
      wait_nibs(2, 200, ok);
      got = {nibq[1], nibq[0]};
      checks++;
      if (!ok || got !== 8'hA5) begin
         errors++;
         $display("FAIL single_byte: got %h (ok=%0d) expected a5", got, ok);
      end
      wait_idle(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_idle: got busy=%b expected 0", busy);
      end
      checks++;
      if (min_stable < SETUP_CYC) begin
         errors++;
         $display("FAIL single_setup: got %0d expected >= %0d", min_stable, SETUP_CYC);
      end
      checks++;
      if (data_moved) begin
         errors++;
         $display("FAIL single_data_stable: got moved=1 expected 0");
      end
   endtask

   task automatic test_back_to_back;
      int w[6];
      bit ok;
      logic [7:0] got;
      rd_en    = 1'b1;
      rd_delay = 0;
      nibq.delete();
      for (int i = 0; i < 6; i++) begin
         push(8'(i + 1), w[i]);
         if (i == 4) begin
            checks++;
            if (tx_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_ready_drop: got %b expected 0", tx_ready);
            end
         end
      end
      checks++;
      if (w[0] != 0 || w[1] != 0 || w[2] != 0 || w[3] != 0 || w[4] != 0 || w[5] == 0) begin
         errors++;
         $display("FAIL b2b_accept: got waits %0d %0d %0d %0d %0d %0d expected 0 0 0 0 0 >0",
                  w[0], w[1], w[2], w[3], w[4], w[5]);
      end
      wait_nibs(12, 2000, ok);
      checks++;
      if (!ok || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_busy_last: got ok=%0d busy=%b expected 1 1", ok, busy);
      end
      for (int i = 0; i < 6; i++) begin
         got = {nibq[2*i+1], nibq[2*i]};
         checks++;
         if (got !== 8'(i + 1)) begin
            errors++;
            $display("FAIL b2b_byte%0d: got %h expected %h", i, got, 8'(i + 1));
         end
      end
      wait_idle(200, ok);
      checks++;
      if (!ok || nibq.size() != 12) begin
         errors++;
         $display("FAIL b2b_idle: got busy=%b nibbles=%0d expected 0 12", busy, nibq.size());
      end
   endtask

   task automatic test_slow_reader;
      int w;
      bit ok;
      logic [7:0] g0;
      logic [7:0] g1;
      rd_en      = 1'b1;
      rd_delay   = 50;
      nibq.delete();
      data_moved = 1'b0;
      min_hi     = 1000;
      push(8'hC3, w);
      push(8'h5A, w);
      wait_nibs(4, 3000, ok);
      wait_idle(500, ok);
      g0 = {nibq[1], nibq[0]};
      g1 = {nibq[3], nibq[2]};
      checks++;
      if (!ok || nibq.size() != 4 || g0 !== 8'hC3 || g1 !== 8'h5A) begin
         errors++;
         $display("FAIL slow_bytes: got %h %h n=%0d expected c3 5a n=4", g0, g1, nibq.size());
      end
      checks++;
      if (min_hi < 50) begin
         errors++;
         $display("FAIL slow_stb_hold: got %0d expected >= 50", min_hi);
      end
      checks++;
      if (data_moved) begin
         errors++;
         $display("FAIL slow_data_stable: got moved=1 expected 0");
      end
      rd_delay = 0;
   endtask

   task automatic test_reset_mid;
      int w;
      int n;
      bit ok;
      logic [7:0] got;
      rd_en = 1'b0;
      nibq.delete();
      push(8'h77, w);
      push(8'h88, w);
      wait_stb(1'b1, 20, n);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (uio_out[4] !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_wait_hi: got stb=%b expected 1", uio_out[4]);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (uio_out !== 8'h00 || busy !== 1'b0 || uio_oe !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_clear: got out=%h busy=%b oe=%h expected 00 0 00",
                  uio_out, busy, uio_oe);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_fifo_empty: got busy=%b rdy=%b expected 0 1", busy, tx_ready);
      end
      nibq.delete();
      rd_en = 1'b1;
      push(8'h3C, w);
      wait_nibs(2, 200, ok);
      wait_idle(200, ok);
      repeat (30) @(posedge clk);
      #1;
      got = {nibq[1], nibq[0]};
      checks++;
      if (got !== 8'h3C || nibq.size() != 2) begin
         errors++;
         $display("FAIL rstmid_next: got %h n=%0d expected 3c n=2", got, nibq.size());
      end
   endtask

   task automatic test_timeout;
      int w;
      int n;
      bit ok;
      logic [7:0] got;
      rd_en = 1'b0;
      nibq.delete();
      push(8'h11, w);
      push(8'h22, w);
      wait_stb(1'b1, 20, n);
`ifdef UIO_TX_TIMEOUT_EN
      wait_stb(1'b0, 100, n);
      checks++;
      if (n != TIMEOUT) begin
         errors++;
         $display("FAIL to_stb_fall: got %0d cycles expected %0d", n, TIMEOUT);
      end
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL to_err_set: got %b expected 1", timeout_err);
      end
      nibq.delete();
      rd_en = 1'b1;
      wait_nibs(2, 300, ok);
      wait_idle(300, ok);
      got = {nibq[1], nibq[0]};
      checks++;
      if (got !== 8'h22 || nibq.size() != 2) begin
         errors++;
         $display("FAIL to_next_byte: got %h n=%0d expected 22 n=2", got, nibq.size());
      end
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL to_err_sticky: got %b expected 1", timeout_err);
      end
`else
      ok = 1'b1;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (uio_out[4] !== 1'b1 || timeout_err !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL noto_hold: got stb=%b err=%b expected 1 0", uio_out[4], timeout_err);
      end
      rd_en = 1'b1;
      wait_nibs(4, 400, ok);
      wait_idle(300, ok);
      checks++;
      if ({nibq[1], nibq[0]} !== 8'h11 || {nibq[3], nibq[2]} !== 8'h22 || timeout_err !== 1'b0)
      begin
         errors++;
         $display("FAIL noto_bytes: got %h %h err=%b expected 11 22 0",
                  {nibq[1], nibq[0]}, {nibq[3], nibq[2]}, timeout_err);
      end
`endif
   endtask

   initial begin
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_slow_reader();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
